// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file and a local preload/inspect port.
// SCL/SDA are oversampled through 2-FF synchronizers. START/STOP are detected on the
// synced lines and override bit handling in every state. Bus writes are reported by a
// one-cycle strobe.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | bus free or after reset; only START/STOP are acted on
// DEV_ADDR  | shifting the 7-bit device address plus R/W
// DEV_ACK   | pulling SDA low to acknowledge our device address
// REG_ADDR  | shifting the register pointer byte
// REG_ACK   | acknowledging the register pointer byte
// WR_DATA   | shifting a data byte to be written at the pointer
// WR_ACK    | acknowledging a written data byte
// RD_DATA   | driving reg[pointer] onto SDA, MSB first
// RD_MACK   | SDA released, sampling the master's ACK/NACK
// WAIT_STOP | transfer not for us, or read ended; wait for START/STOP
module i2c_target_regfile #(
    parameter logic [6:0] TARGET_ADDR = 7'h53,
    parameter int         NUM_REGS    = 16,
    localparam int        ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic              loc_we,
    input  logic [7:0]        loc_wdata,
    output logic [7:0]        loc_rdata,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_REG_ADDR,
        ST_REG_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_MACK,
        ST_WAIT_STOP
    } state_t;

    // synchronizer stages plus one delayed copy for edge detection
    logic scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_d1_q, scl_d1_d;
    logic sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_d1_q, sda_d1_d;

    state_t            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [7:0]        loc_rdata_q, loc_rdata_d;
    logic [7:0]        regs_q [NUM_REGS];
    logic [7:0]        regs_d [NUM_REGS];

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;

    assign scl_rise  = scl_s2_q & ~scl_d1_q;
    assign scl_fall  = ~scl_s2_q & scl_d1_q;
    assign start_det = scl_s2_q & scl_d1_q & sda_d1_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_d1_q & ~sda_d1_q & sda_s2_q;
    assign rx_byte   = {shift_q[6:0], sda_s2_q};

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign loc_rdata = loc_rdata_q;

    // next-state logic: synchronizers, local port, bus protocol FSM and register file
    always_comb begin
        scl_s1_d    = scl_i;
        scl_s2_d    = scl_s1_q;
        scl_d1_d    = scl_s2_q;
        sda_s1_d    = sda_i;
        sda_s2_d    = sda_s1_q;
        sda_d1_d    = sda_s2_q;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        regs_d      = regs_q;
        loc_rdata_d = regs_q[loc_addr];

        // local write first so a same-cycle bus write to the same register overrides it
        if (loc_we) begin
            regs_d[loc_addr] = loc_wdata;
        end

        if (start_det) begin
            state_d   = ST_DEV_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_DEV_ADDR: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[7:1] == TARGET_ADDR) begin
                            state_d  = ST_DEV_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = shift_q[0];
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                ST_DEV_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            state_d  = ST_RD_DATA;
                            shift_d  = regs_q[ptr_q];
                            sda_oe_d = ~regs_q[ptr_q][7];
                        end else begin
                            state_d  = ST_REG_ADDR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_REG_ADDR: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        ptr_d     = shift_q[ADDR_W-1:0];
                        state_d   = ST_REG_ACK;
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = 4'd0;
                    end
                end
                ST_REG_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        state_d   = ST_WR_DATA;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // commit on the 8th rise; a repeated START never reaches here
                        if (bit_cnt_q == 4'd7) begin
                            regs_d[ptr_q] = rx_byte;
                            wr_strobe_d   = 1'b1;
                            wr_addr_d     = ptr_q;
                            wr_data_d     = rx_byte;
                            ptr_d         = ptr_q + 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d   = ST_WR_ACK;
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = 4'd0;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d   = ST_RD_MACK;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                ST_RD_MACK: begin
                    // bit_cnt marks an ACKed byte so the next one is loaded on the SCL fall
                    if (scl_rise) begin
                        if (!sda_s2_q) begin
                            ptr_d     = ptr_q + 1'b1;
                            bit_cnt_d = 4'd1;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        state_d   = ST_RD_DATA;
                        shift_d   = regs_q[ptr_q];
                        sda_oe_d  = ~regs_q[ptr_q][7];
                        bit_cnt_d = 4'd0;
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // state registers; synchronizers reset to the idle-high bus level
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scl_s1_q    <= 1'b1;
            scl_s2_q    <= 1'b1;
            scl_d1_q    <= 1'b1;
            sda_s1_q    <= 1'b1;
            sda_s2_q    <= 1'b1;
            sda_d1_q    <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            rw_q        <= 1'b0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
            loc_rdata_q <= 8'h00;
            regs_q      <= '{default: 8'h00};
        end else begin
            scl_s1_q    <= scl_s1_d;
            scl_s2_q    <= scl_s2_d;
            scl_d1_q    <= scl_d1_d;
            sda_s1_q    <= sda_s1_d;
            sda_s2_q    <= sda_s2_d;
            sda_d1_q    <= sda_d1_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            loc_rdata_q <= loc_rdata_d;
            regs_q      <= regs_d;
        end
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: bit-banged I2C master on an open-drain SDA line.
module tb_i2c_target_regfile;

    localparam int Q = 6;

    logic       clk;
    logic       reset_n;
    logic       scl;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic [3:0] loc_addr;
    logic       loc_we;
    logic [7:0] loc_wdata;
    logic [7:0] loc_rdata;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int n_chk;
    int n_fail;
    int oe_cnt;
    int busy_cnt;
    int s_cnt;
    logic [3:0] s_addr [32];
    logic [7:0] s_data [32];

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_regfile dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl_i     (scl),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .loc_addr  (loc_addr),
        .loc_we    (loc_we),
        .loc_wdata (loc_wdata),
        .loc_rdata (loc_rdata),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observation log of strobes and SDA/busy activity
    initial begin
        oe_cnt = 0;
        busy_cnt = 0;
        s_cnt = 0;
    end
    always @(negedge clk) begin
        if (sda_oe === 1'b1) oe_cnt = oe_cnt + 1;
        if (busy === 1'b1) busy_cnt = busy_cnt + 1;
        if (wr_strobe === 1'b1) begin
            if (s_cnt < 32) begin
                s_addr[s_cnt] = wr_addr;
                s_data[s_cnt] = wr_data;
            end
            s_cnt = s_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq();
        scl = 1'b1;   wq();
        sda_m = 1'b0; wq();
        scl = 1'b0;   wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl = 1'b1;   wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; wq();
        scl = 1'b1; wq(); wq();
        scl = 1'b0; wq();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wq();
        scl = 1'b1; wq();
        b = sda_bus; wq();
        scl = 1'b0; wq();
    endtask

    // last data bit with a local write landing in the bus commit cycle
    task automatic write_bit_collide(input logic b);
        sda_m = b; wq();
        scl = 1'b1;
        @(negedge clk); @(negedge clk);
        loc_we = 1'b1;
        @(negedge clk);
        loc_we = 1'b0;
        check("collide_rdata_old", loc_rdata, 8'h00);
        check("collide_strobe", wr_strobe, 1'b1);
        check("collide_wr_data", wr_data, 8'h88);
        @(negedge clk);
        check("collide_rdata_new", loc_rdata, 8'h88);
        repeat (2 * Q - 4) @(negedge clk);
        scl = 1'b0; wq();
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        write_bit(mack);
    endtask

    task automatic poke(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        loc_addr = a; loc_wdata = d; loc_we = 1'b1;
        @(negedge clk);
        loc_we = 1'b0;
    endtask

    task automatic peek(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        loc_addr = a;
        @(negedge clk); @(negedge clk);
        d = loc_rdata;
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         base;
        int         oe_base;
        int         busy_base;

        n_chk = 0;
        n_fail = 0;
        reset_n = 1'b0;
        scl = 1'b1;
        sda_m = 1'b1;
        loc_addr = 4'd0;
        loc_we = 1'b0;
        loc_wdata = 8'h00;
        repeat (4) @(negedge clk);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_strobe", wr_strobe, 1'b0);
        check("rst_wr_addr", wr_addr, 4'h0);
        check("rst_wr_data", wr_data, 8'h00);
        check("rst_loc_rdata", loc_rdata, 8'h00);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: write A5,3C starting at reg 2
        base = s_cnt;
        i2c_start();
        send_byte(8'hA6, ack); check("t1_ack_dev", ack, 1'b0);
        check("t1_busy", busy, 1'b1);
        send_byte(8'h02, ack); check("t1_ack_reg", ack, 1'b0);
        send_byte(8'hA5, ack); check("t1_ack_d0", ack, 1'b0);
        send_byte(8'h3C, ack); check("t1_ack_d1", ack, 1'b0);
        check("t1_busy_before_stop", busy, 1'b1);
        i2c_stop();
        check("t1_busy_after_stop", busy, 1'b0);
        check("t1_strobes", s_cnt - base, 2);
        check("t1_s0_addr", s_addr[base], 4'h2);
        check("t1_s0_data", s_data[base], 8'hA5);
        check("t1_s1_addr", s_addr[base+1], 4'h3);
        check("t1_s1_data", s_data[base+1], 8'h3C);
        peek(4'h2, d); check("t1_reg2", d, 8'hA5);
        peek(4'h3, d); check("t1_reg3", d, 8'h3C);

        // 2: preload then read two bytes through a repeated START
        poke(4'h2, 8'h11);
        poke(4'h3, 8'h22);
        i2c_start();
        send_byte(8'hA6, ack); check("t2_ack_dev", ack, 1'b0);
        send_byte(8'h02, ack); check("t2_ack_reg", ack, 1'b0);
        i2c_start();
        send_byte(8'hA7, ack); check("t2_ack_devr", ack, 1'b0);
        recv_byte(1'b0, d); check("t2_rd0", d, 8'h11);
        recv_byte(1'b1, d); check("t2_rd1", d, 8'h22);
        check("t2_released", sda_oe, 1'b0);
        i2c_stop();
        check("t2_busy_after_stop", busy, 1'b0);

        // 3: foreign address is ignored
        base = s_cnt;
        oe_base = oe_cnt;
        busy_base = busy_cnt;
        i2c_start();
        send_byte(8'h3A, ack); check("t3_nack_dev", ack, 1'b1);
        send_byte(8'h55, ack); check("t3_nack_data", ack, 1'b1);
        i2c_stop();
        check("t3_oe_never", oe_cnt - oe_base, 0);
        check("t3_busy_never", busy_cnt - busy_base, 0);
        check("t3_no_strobe", s_cnt - base, 0);
        peek(4'h2, d); check("t3_reg2", d, 8'h11);
        peek(4'h5, d); check("t3_reg5", d, 8'h00);

        // 4: pointer wrap and upper pointer bits ignored
        base = s_cnt;
        i2c_start();
        send_byte(8'hA6, ack); check("t4_ack_dev", ack, 1'b0);
        send_byte(8'h0F, ack);
        send_byte(8'h01, ack);
        send_byte(8'h02, ack); check("t4_ack_d1", ack, 1'b0);
        i2c_stop();
        peek(4'hF, d); check("t4_reg15", d, 8'h01);
        peek(4'h0, d); check("t4_reg0", d, 8'h02);
        check("t4_s1_addr", s_addr[base+1], 4'h0);
        i2c_start();
        send_byte(8'hA6, ack);
        send_byte(8'h13, ack); check("t4_ack_reg13", ack, 1'b0);
        send_byte(8'h99, ack);
        i2c_stop();
        check("t4_s2_addr", s_addr[base+2], 4'h3);
        peek(4'h3, d); check("t4_reg3", d, 8'h99);

        // 5: reset while driving a 0 read bit
        poke(4'h5, 8'h3C);
        i2c_start();
        send_byte(8'hA6, ack);
        send_byte(8'h05, ack);
        i2c_start();
        send_byte(8'hA7, ack); check("t5_ack_devr", ack, 1'b0);
        check("t5_driving0", sda_oe, 1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        check("t5_oe_after_rst", sda_oe, 1'b0);
        check("t5_busy_after_rst", busy, 1'b0);
        reset_n = 1'b1;
        i2c_stop();
        peek(4'h2, d); check("t5_reg2_cleared", d, 8'h00);
        peek(4'h5, d); check("t5_reg5_cleared", d, 8'h00);
        base = s_cnt;
        i2c_start();
        send_byte(8'hA6, ack); check("t5_post_ack_dev", ack, 1'b0);
        send_byte(8'h07, ack);
        send_byte(8'h5A, ack); check("t5_post_ack_data", ack, 1'b0);
        i2c_stop();
        check("t5_post_strobe_addr", s_addr[base], 4'h7);
        i2c_start();
        send_byte(8'hA6, ack);
        send_byte(8'h07, ack);
        i2c_start();
        send_byte(8'hA7, ack);
        recv_byte(1'b1, d); check("t5_post_read", d, 8'h5A);
        i2c_stop();

        // 6: same-cycle local and bus write to reg 4
        loc_addr = 4'h4;
        loc_wdata = 8'h77;
        i2c_start();
        send_byte(8'hA6, ack);
        send_byte(8'h04, ack); check("t6_ack_reg", ack, 1'b0);
        for (int i = 7; i >= 1; i--) write_bit(1'((8'h88 >> i) & 8'h01));
        write_bit_collide(1'b0);
        read_bit(ack); check("t6_ack_data", ack, 1'b0);
        i2c_stop();
        peek(4'h4, d); check("t6_reg4", d, 8'h88);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
